// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: architectural widths and register-address types.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  // Architectural zero register x0
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] regaddr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination pending, writeback
// clears it. Also provides RAW/WAW busy lookups and flags writebacks that hit
// a register with no pending producer.
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int ADDRSIZE = REG_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                regwr,
  input  logic [ADDRSIZE-1:0] rd,
  input  logic                issue,
  input  logic [ADDRSIZE-1:0] issue_rd,
  input  logic [ADDRSIZE-1:0] rs1,
  input  logic [ADDRSIZE-1:0] rs2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                rd_busy,
  output logic                wb_err
);

  localparam int   NREGS  = 2 ** ADDRSIZE;
  localparam logic BYP_EN = (BYPASS != 0);
  localparam logic ZR_EN  = (ZERO_REG != 0);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             wb_err_q, wb_err_d;
  logic             wr_live;
  logic             rs1_wb_hit, rs2_wb_hit, rd_wb_hit;

  // A writeback that actually targets an architectural register (x0 excluded when hardwired)
  assign wr_live = regwr && !(ZR_EN && (rd == ADDRSIZE'(REG_ZERO)));

  // Next busy state: writeback clears, issue sets and wins over a same-cycle clear
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (regwr && (rd == ADDRSIZE'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (issue && (issue_rd == ADDRSIZE'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
    if (ZR_EN) begin
      busy_d[0] = 1'b0;
    end
  end

  // Writeback with no outstanding producer is reported one cycle later
  always_comb begin
    wb_err_d = wr_live && !busy_q[rd];
  end

  // Scoreboard and error-pulse registers; reset discards all pending state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
    end
  end

  // A same-cycle writeback resolves the hazard only when its data is forwarded
  assign rs1_wb_hit = BYP_EN && regwr && (rd == rs1);
  assign rs2_wb_hit = BYP_EN && regwr && (rd == rs2);
  assign rd_wb_hit  = BYP_EN && regwr && (rd == issue_rd);

  assign rs1_busy = busy_q[rs1] && !rs1_wb_hit;
  assign rs2_busy = busy_q[rs2] && !rs2_wb_hit;
  assign rd_busy  = busy_q[issue_rd] && !rd_wb_hit;
  assign wb_err   = wb_err_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-through bypass, hardwired x0 and a busy
// scoreboard that lets decode stall on RAW hazards.
module regfile_sb
  import riscv_pkg::*;
#(
  parameter int ADDRSIZE = REG_ADDR_W,
  parameter int WORDSIZE = XLEN,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                regwr,
  input  logic [ADDRSIZE-1:0] rd,
  input  logic [WORDSIZE-1:0] rddata,
  input  logic [ADDRSIZE-1:0] rs1,
  input  logic [ADDRSIZE-1:0] rs2,
  output logic [WORDSIZE-1:0] rs1data,
  output logic [WORDSIZE-1:0] rs2data,
  input  logic                issue,
  input  logic [ADDRSIZE-1:0] issue_rd,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                rd_busy,
  output logic                hazard,
  output logic                wb_err
);

  localparam int   NREGS  = 2 ** ADDRSIZE;
  localparam logic BYP_EN = (BYPASS != 0);
  localparam logic ZR_EN  = (ZERO_REG != 0);

  logic [WORDSIZE-1:0] file_q [NREGS];
  logic                wr_en;

  // Read-port mux: x0 forced to zero first, then same-cycle forwarding, then storage
  function automatic logic [WORDSIZE-1:0] read_mux(
    input logic [ADDRSIZE-1:0] addr,
    input logic [WORDSIZE-1:0] stored,
    input logic                wr,
    input logic [ADDRSIZE-1:0] wr_addr,
    input logic [WORDSIZE-1:0] wr_data
  );
    logic [WORDSIZE-1:0] val;
    val = stored;
    if (ZR_EN && (addr == '0)) begin
      val = '0;
    end else if (BYP_EN && wr && (wr_addr == addr)) begin
      val = wr_data;
    end
    return val;
  endfunction

  assign wr_en = regwr && !(ZR_EN && (rd == '0));

  // Register storage: full clear on reset, otherwise one write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        file_q[i] <= '0;
      end
    end else if (wr_en) begin
      file_q[rd] <= rddata;
    end
  end

  // Combinational read ports with bypass
  always_comb begin
    rs1data = read_mux(rs1, file_q[rs1], regwr, rd, rddata);
    rs2data = read_mux(rs2, file_q[rs2], regwr, rd, rddata);
  end

  regfile_scoreboard #(
    .ADDRSIZE (ADDRSIZE),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .regwr    (regwr),
    .rd       (rd),
    .issue    (issue),
    .issue_rd (issue_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .wb_err   (wb_err)
  );

  assign hazard = rs1_busy | rs2_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a forwarding and a non-forwarding instance share
// stimulus; a reference model predicts each cycle's outputs into a queue.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwr;
  logic [4:0]  rd;
  logic [63:0] rddata;
  logic [4:0]  rs1, rs2;
  logic        issue;
  logic [4:0]  issue_rd;

  logic [63:0] rs1data, rs2data, rs1data_nb, rs2data_nb;
  logic        rs1_busy, rs2_busy, rd_busy, hazard, wb_err;
  logic        rs1_busy_nb, rs2_busy_nb, rd_busy_nb, hazard_nb, wb_err_nb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.ADDRSIZE(5), .WORDSIZE(64), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .regwr(regwr), .rd(rd), .rddata(rddata),
    .rs1(rs1), .rs2(rs2), .rs1data(rs1data), .rs2data(rs2data),
    .issue(issue), .issue_rd(issue_rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .hazard(hazard), .wb_err(wb_err)
  );

  regfile_sb #(.ADDRSIZE(5), .WORDSIZE(64), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rst(rst), .regwr(regwr), .rd(rd), .rddata(rddata),
    .rs1(rs1), .rs2(rs2), .rs1data(rs1data_nb), .rs2data(rs2data_nb),
    .issue(issue), .issue_rd(issue_rd),
    .rs1_busy(rs1_busy_nb), .rs2_busy(rs2_busy_nb), .rd_busy(rd_busy_nb),
    .hazard(hazard_nb), .wb_err(wb_err_nb)
  );

  typedef struct {
    logic [63:0] r1, r2, r1nb, r2nb;
    logic        b1, b2, rdb, hz;
    logic        b1nb, b2nb, rdbnb, hznb;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [63:0] m_file [32];
  logic [31:0] m_busy;
  logic        m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    logic h1, h2, hd;
    h1 = regwr && (rd == rs1);
    h2 = regwr && (rd == rs2);
    hd = regwr && (rd == issue_rd);
    e.r1nb = (rs1 == 5'd0) ? 64'd0 : m_file[rs1];
    e.r2nb = (rs2 == 5'd0) ? 64'd0 : m_file[rs2];
    e.r1   = (rs1 != 5'd0 && h1) ? rddata : e.r1nb;
    e.r2   = (rs2 != 5'd0 && h2) ? rddata : e.r2nb;
    e.b1nb  = m_busy[rs1];
    e.b2nb  = m_busy[rs2];
    e.rdbnb = m_busy[issue_rd];
    e.b1  = m_busy[rs1] && !h1;
    e.b2  = m_busy[rs2] && !h2;
    e.rdb = m_busy[issue_rd] && !hd;
    e.hz   = e.b1 || e.b2;
    e.hznb = e.b1nb || e.b2nb;
    e.err  = m_err;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_file[i] = 64'd0;
    m_busy = 32'd0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      m_err = regwr && (rd != 5'd0) && !m_busy[rd];
      if (regwr && rd != 5'd0) m_file[rd] = rddata;
      if (regwr) m_busy[rd] = 1'b0;
      if (issue && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    end
  endtask

  // One clock: predict from current inputs, compare at the falling edge, advance model
  task automatic step();
    exp_t e;
    exp_q.push_back(predict());
    @(negedge clk);
    e = exp_q.pop_front();
    chk("rs1data",     rs1data,     e.r1);
    chk("rs2data",     rs2data,     e.r2);
    chk("rs1data_nb",  rs1data_nb,  e.r1nb);
    chk("rs2data_nb",  rs2data_nb,  e.r2nb);
    chk("rs1_busy",    64'(rs1_busy),    64'(e.b1));
    chk("rs2_busy",    64'(rs2_busy),    64'(e.b2));
    chk("rd_busy",     64'(rd_busy),     64'(e.rdb));
    chk("hazard",      64'(hazard),      64'(e.hz));
    chk("rs1_busy_nb", 64'(rs1_busy_nb), 64'(e.b1nb));
    chk("rs2_busy_nb", 64'(rs2_busy_nb), 64'(e.b2nb));
    chk("rd_busy_nb",  64'(rd_busy_nb),  64'(e.rdbnb));
    chk("hazard_nb",   64'(hazard_nb),   64'(e.hznb));
    chk("wb_err",      64'(wb_err),      64'(e.err));
    chk("wb_err_nb",   64'(wb_err_nb),   64'(e.err));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    regwr = 1'b0; rd = 5'd0; rddata = 64'd0; issue = 1'b0; issue_rd = 5'd0;
  endtask

  initial begin
    rst = 1'b1; idle(); rs1 = 5'd0; rs2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Reset state
    rs1 = 5'd5; rs2 = 5'd31; #1;
    chk("rst_rs1data", rs1data, 64'd0);
    chk("rst_rs2data", rs2data, 64'd0);
    chk("rst_busy", 64'({rs1_busy, rs2_busy, rd_busy, hazard}), 64'd0);
    chk("rst_wb_err", 64'(wb_err), 64'd0);
    step();

    // Write-through bypass vs. old contents
    regwr = 1'b1; rd = 5'd3; rddata = 64'hDEADBEEF_00000001; rs1 = 5'd3; #1;
    chk("byp_same", rs1data, 64'hDEADBEEF_00000001);
    chk("nobyp_same", rs1data_nb, 64'd0);
    step();
    idle(); #1;
    chk("byp_next", rs1data, 64'hDEADBEEF_00000001);
    chk("nobyp_next", rs1data_nb, 64'hDEADBEEF_00000001);
    step();

    // x0 ignores writes and is never busy
    regwr = 1'b1; rd = 5'd0; rddata = 64'hFFFF_FFFF_FFFF_FFFF; rs1 = 5'd0;
    step();
    idle(); #1;
    chk("x0_read", rs1data, 64'd0);
    issue = 1'b1; issue_rd = 5'd0;
    step();
    idle(); #1;
    chk("x0_busy", 64'(rs1_busy), 64'd0);
    step();

    // RAW on x7 resolved by writeback
    issue = 1'b1; issue_rd = 5'd7;
    step();
    idle(); rs2 = 5'd7; #1;
    chk("raw_busy", 64'(rs2_busy), 64'd1);
    chk("raw_hazard", 64'(hazard), 64'd1);
    step();
    regwr = 1'b1; rd = 5'd7; rddata = 64'h42; #1;
    chk("wb_resolve_busy", 64'(rs2_busy), 64'd0);
    chk("wb_resolve_data", rs2data, 64'h42);
    chk("wb_nb_still_busy", 64'(rs2_busy_nb), 64'd1);
    step();
    idle(); #1;
    chk("busy_cleared", 64'(rs2_busy), 64'd0);
    chk("busy_cleared_nb", 64'(rs2_busy_nb), 64'd0);
    step();

    // Simultaneous issue and writeback: set wins, data still written
    issue = 1'b1; issue_rd = 5'd9;
    step();
    regwr = 1'b1; rd = 5'd9; rddata = 64'h99; #1;
    chk("waw_rd_busy_nb", 64'(rd_busy_nb), 64'd1);
    step();
    idle(); rs1 = 5'd9; #1;
    chk("set_wins", 64'(rs1_busy), 64'd1);
    chk("set_wins_data", rs1data, 64'h99);
    chk("no_wb_err", 64'(wb_err), 64'd0);
    step();

    // Writeback to a non-busy register pulses wb_err once
    regwr = 1'b1; rd = 5'd10; rddata = 64'h5;
    step();
    idle(); #1;
    chk("wb_err_pulse", 64'(wb_err), 64'd1);
    step();
    chk("wb_err_one_cycle", 64'(wb_err), 64'd0);
    step();

    // Populate everything, then reset mid-stream with a competing write
    for (int i = 1; i < 32; i++) begin
      regwr = 1'b1; rd = 5'(i); rddata = {$urandom, $urandom};
      issue = 1'b1; issue_rd = 5'(i);
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      rs1 = 5'($urandom); rs2 = 5'($urandom);
      step();
    end
    rst = 1'b1; regwr = 1'b1; rd = 5'd4; rddata = 64'h1234;
    step();
    rst = 1'b0; idle();
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i); issue_rd = 5'(i); #1;
      chk("post_rst_data", rs1data | rs2data, 64'd0);
      chk("post_rst_busy", 64'({rs1_busy, rs2_busy, rd_busy}), 64'd0);
      step();
    end

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      regwr    = $urandom_range(0, 1) == 1;
      rd       = 5'($urandom_range(0, 7));
      rddata   = {$urandom, $urandom};
      issue    = $urandom_range(0, 1) == 1;
      issue_rd = 5'($urandom_range(0, 7));
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      step();
    end
    rst = 1'b0; idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
